// File: rtl/sqrt_rem_seq_if.sv
// Handshake and result bus for the sequential square-root unit.
interface sqrt_rem_seq_if #(
    parameter int unsigned N = 16
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic           round;
    logic           out_valid;
    logic           out_ready;
    logic [N/2-1:0] root;
    logic [N/2:0]   rem;
    logic           exact;
    logic           sat;

    modport master (
        output flush, in_valid, a, round, out_ready,
        input  in_ready, out_valid, root, rem, exact, sat
    );

    modport slave (
        input  flush, in_valid, a, round, out_ready,
        output in_ready, out_valid, root, rem, exact, sat
    );
endinterface

// File: rtl/sqrt_rem_seq.sv
// Sequential digit-by-digit integer square root with floor remainder,
// optional round-to-nearest root and saturation flag. S root bits per clock.
module sqrt_rem_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned S = 1
) (
    input logic           clk,
    input logic           rst,
    sqrt_rem_seq_if.slave bus
);
    localparam int unsigned H  = N / 2;
    localparam int unsigned L  = N / (2 * S);
    localparam int unsigned RW = H + 3;
    localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q;
    logic [N-1:0]   a_q;
    logic           round_q;
    logic [H-1:0]   q_q;
    logic [RW-1:0]  r_q;
    logic [CW-1:0]  cnt_q;
    logic [H-1:0]   root_q;
    logic [H:0]     rem_q;
    logic           exact_q;
    logic           sat_q;
    logic           out_valid_q;

    logic [N-1:0]   a_d;
    logic [H-1:0]   q_d;
    logic [RW-1:0]  r_d;
    logic [RW-1:0]  trial;
    logic [RW-1:0]  cmp;
    logic           inc;
    logic           sat_d;
    logic [H-1:0]   root_d;

    // S restoring root-digit steps per clock, consuming radicand bit pairs MSB-first
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        r_d   = r_q;
        trial = '0;
        cmp   = '0;
        for (int unsigned i = 0; i < S; i++) begin
            trial = {r_d[RW-3:0], a_d[N-1 -: 2]};
            cmp   = {RW'(q_d) << 2} | RW'(1);
            if (trial >= cmp) begin
                r_d = trial - cmp;
                q_d = {q_d[H-2:0], 1'b1};
            end else begin
                r_d = trial;
                q_d = {q_d[H-2:0], 1'b0};
            end
            a_d = {a_d[N-3:0], 2'b00};
        end
    end

    // Round-to-nearest adjustment of the final floor root, saturating at all-ones
    always_comb begin
        inc    = round_q && (r_d > RW'(q_d));
        sat_d  = inc && (&q_d);
        root_d = (inc && !sat_d) ? q_d + H'(1) : q_d;
    end

    // Accept only while idle and not being flushed
    assign bus.in_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.out_valid = out_valid_q;
    assign bus.root      = root_q;
    assign bus.rem       = rem_q;
    assign bus.exact     = exact_q;
    assign bus.sat       = sat_q;

    // Control FSM, datapath iteration and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            round_q     <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            exact_q     <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        round_q <= bus.round;
                        q_q     <= '0;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(L - 1)) begin
                        root_q      <= root_d;
                        rem_q       <= r_d[H:0];
                        exact_q     <= (r_d == '0);
                        sat_q       <= sat_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_rem_seq.sv
// Directed and swept checks of sqrt_rem_seq in three configurations:
// sel 0 = N8/S1, sel 1 = N16/S2, sel 2 = N16/S1.
module tb_sqrt_rem_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  sel;
    logic        in_valid_t, rnd_t, flush_t, out_ready_t;
    logic [15:0] a_t;

    logic        m_in_ready, m_out_valid, m_exact, m_sat;
    logic [15:0] m_root;
    logic [16:0] m_rem;

    int errors = 0;
    int checks = 0;

    sqrt_rem_seq_if #(.N(8))  if0 ();
    sqrt_rem_seq_if #(.N(16)) if1 ();
    sqrt_rem_seq_if #(.N(16)) if2 ();

    sqrt_rem_seq #(.N(8),  .S(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    sqrt_rem_seq #(.N(16), .S(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    sqrt_rem_seq #(.N(16), .S(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    assign if0.flush = flush_t;  assign if0.out_ready = out_ready_t && (sel == 2'd0);
    assign if1.flush = flush_t;  assign if1.out_ready = out_ready_t && (sel == 2'd1);
    assign if2.flush = flush_t;  assign if2.out_ready = out_ready_t && (sel == 2'd2);
    assign if0.in_valid = in_valid_t && (sel == 2'd0);
    assign if1.in_valid = in_valid_t && (sel == 2'd1);
    assign if2.in_valid = in_valid_t && (sel == 2'd2);
    assign if0.a = a_t[7:0];  assign if1.a = a_t;  assign if2.a = a_t;
    assign if0.round = rnd_t; assign if1.round = rnd_t; assign if2.round = rnd_t;

    always_comb begin
        case (sel)
            2'd1: begin
                m_in_ready = if1.in_ready; m_out_valid = if1.out_valid;
                m_root = if1.root; m_rem = if1.rem; m_exact = if1.exact; m_sat = if1.sat;
            end
            2'd2: begin
                m_in_ready = if2.in_ready; m_out_valid = if2.out_valid;
                m_root = if2.root; m_rem = if2.rem; m_exact = if2.exact; m_sat = if2.sat;
            end
            default: begin
                m_in_ready = if0.in_ready; m_out_valid = if0.out_valid;
                m_root = 16'(if0.root); m_rem = 17'(if0.rem); m_exact = if0.exact; m_sat = if0.sat;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference floor square root by upward search
    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic send(input logic [1:0] k, input logic [15:0] av, input logic rv);
        int guard = 0;
        @(negedge clk);
        sel = k; a_t = av; rnd_t = rv; in_valid_t = 1'b1;
        while (!m_in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid_t = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!m_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        chk({tag, "_busy_before_consume"}, 32'(m_in_ready), 32'd0);
        out_ready_t = 1'b1;
        @(posedge clk);
        #1 out_ready_t = 1'b0;
        chk({tag, "_valid_dropped"}, 32'(m_out_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(m_in_ready), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [1:0] k, input int av, input logic rv);
        int rf, rm, er, es, hmax;
        hmax = (k == 2'd0) ? 15 : 255;
        rf = isqrt(av);
        rm = av - rf * rf;
        er = rf; es = 0;
        if (rv && rm > rf) begin
            if (rf == hmax) es = 1;
            else er = rf + 1;
        end
        chk({tag, "_root"},  32'(m_root),  32'(er));
        chk({tag, "_rem"},   32'(m_rem),   32'(rm));
        chk({tag, "_exact"}, 32'(m_exact), 32'(rm == 0));
        chk({tag, "_sat"},   32'(m_sat),   32'(es));
    endtask

    task automatic do_full(input string tag, input logic [1:0] k, input logic [15:0] av, input logic rv);
        int lat;
        send(k, av, rv);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), (k == 2'd2) ? 32'd8 : 32'd4);
        check_result(tag, k, int'(av), rv);
        consume(tag);
    endtask

    initial begin
        int lat;
        logic seen;
        rst = 1'b1; sel = 2'd0; in_valid_t = 1'b0; rnd_t = 1'b0;
        flush_t = 1'b0; out_ready_t = 1'b0; a_t = '0;
        #23;
        chk("reset_out_valid", 32'(m_out_valid), 32'd0);
        chk("reset_root", 32'(m_root), 32'd0);
        chk("reset_rem", 32'(m_rem), 32'd0);
        chk("reset_exact", 32'(m_exact), 32'd0);
        chk("reset_sat", 32'(m_sat), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 chk("ready_after_reset", 32'(m_in_ready), 32'd1);

        // a=200 with a/round/in_valid wiggled during CALC and DONE
        send(2'd0, 16'd200, 1'b0);
        a_t = 16'hFFFF; rnd_t = 1'b1; in_valid_t = 1'b1;
        wait_done(lat);
        chk("a200_latency", 32'(lat), 32'd4);
        in_valid_t = 1'b0;
        chk("a200_root", 32'(m_root), 32'd14);
        chk("a200_rem", 32'(m_rem), 32'd4);
        chk("a200_exact", 32'(m_exact), 32'd0);
        chk("a200_sat", 32'(m_sat), 32'd0);
        consume("a200");

        // Saturation and exact squares on N=8
        send(2'd0, 16'd255, 1'b1);
        wait_done(lat);
        chk("a255r_root", 32'(m_root), 32'd15);
        chk("a255r_rem", 32'(m_rem), 32'd30);
        chk("a255r_sat", 32'(m_sat), 32'd1);
        consume("a255r");
        do_full("a255f", 2'd0, 16'd255, 1'b0);
        do_full("a144", 2'd0, 16'd144, 1'b0);
        do_full("a0", 2'd0, 16'd0, 1'b1);
        do_full("a12r", 2'd0, 16'd12, 1'b1);
        do_full("a13r", 2'd0, 16'd13, 1'b1);

        // N=16 S=2, result held under back-pressure
        send(2'd1, 16'd65535, 1'b0);
        wait_done(lat);
        chk("big_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("big_hold_valid", 32'(m_out_valid), 32'd1);
            chk("big_hold_root", 32'(m_root), 32'd255);
            chk("big_hold_rem", 32'(m_rem), 32'd510);
            chk("big_hold_ready", 32'(m_in_ready), 32'd0);
        end
        consume("big");

        // Reset two cycles after accept discards the operation
        send(2'd0, 16'd200, 1'b0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_calc_valid", 32'(m_out_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 chk("rst_calc_ready", 32'(m_in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 seen |= m_out_valid;
        end
        chk("rst_calc_no_result", 32'(seen), 32'd0);
        do_full("after_rst", 2'd0, 16'd99, 1'b0);

        // Flush two cycles after accept
        send(2'd0, 16'd200, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) flush_t = 1'b1;
        #1 chk("flush_blocks_ready", 32'(m_in_ready), 32'd0);
        @(posedge clk);
        #1 flush_t = 1'b0;
        #1 chk("flush_ready", 32'(m_in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 seen |= m_out_valid;
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        do_full("after_flush", 2'd0, 16'd99, 1'b0);

        // Flush and reset while DONE
        send(2'd0, 16'd50, 1'b0);
        wait_done(lat);
        chk("done_flush_pre", 32'(m_out_valid), 32'd1);
        @(negedge clk) flush_t = 1'b1;
        @(posedge clk);
        #1 flush_t = 1'b0;
        chk("done_flush_valid", 32'(m_out_valid), 32'd0);
        send(2'd0, 16'd144, 1'b0);
        wait_done(lat);
        #2 rst = 1'b1;
        #1 chk("done_rst_valid", 32'(m_out_valid), 32'd0);
        chk("done_rst_root", 32'(m_root), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Exhaustive N=8 sweep, both rounding modes
        for (int v = 0; v < 256; v++) begin
            do_full("sw8f", 2'd0, 16'(v), 1'b0);
            do_full("sw8r", 2'd0, 16'(v), 1'b1);
        end

        // Random N=16 sweeps plus edge values
        do_full("e1_max", 2'd1, 16'd65535, 1'b1);
        do_full("e2_max", 2'd2, 16'd65535, 1'b1);
        do_full("e2_sq", 2'd2, 16'd65025, 1'b1);
        do_full("e2_mid", 2'd2, 16'd65280, 1'b1);
        for (int n = 0; n < 400; n++) begin
            do_full("rnd16s2", 2'd1, 16'($urandom_range(65535)), 1'($urandom_range(1)));
            do_full("rnd16s1", 2'd2, 16'($urandom_range(65535)), 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
